// File: rtl/qupls4_rename_rd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qupls4_rename_rd
//  Purpose  : Destination-register rename stage. Maps an architectural Rd to
//             a freshly allocated physical register taken from a circular
//             free list. It also reports the previous mapping so that commit
//             can release it later. The output is a one-deep registered
//             valid/ready stage.
//  Optional : `define QUPLS4_RENAME_CKPT_EN adds one rename checkpoint
//             (a RAT copy plus the free-list read pointer).
//  Ports    : clk, rst_n (async, active-low)
//             in_v/in_rd/in_rdz/in_rdy          - upstream handshake
//             out_v/out_prd/out_old_prd/out_rdz - downstream payload
//             out_rdy                           - downstream ready
//             free_v/free_preg                  - commit-time register release
//             free_err                          - pulse: release into full list
//             fl_count                          - free-list occupancy
//             ckpt_save/ckpt_restore            - checkpoint control
//  Revision : 1.0 - initial release
// ============================================================================
module qupls4_rename_rd #(
  parameter int AREGS = 128,
  parameter int PREGS = 256,
  parameter int FLD   = PREGS - AREGS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_v,
  input  logic [$clog2(AREGS)-1:0]   in_rd,
  input  logic                       in_rdz,
  output logic                       in_rdy,
  output logic                       out_v,
  output logic [$clog2(PREGS)-1:0]   out_prd,
  output logic [$clog2(PREGS)-1:0]   out_old_prd,
  output logic                       out_rdz,
  input  logic                       out_rdy,
  input  logic                       free_v,
  input  logic [$clog2(PREGS)-1:0]   free_preg,
  output logic                       free_err,
  output logic [$clog2(FLD+1)-1:0]   fl_count,
  input  logic                       ckpt_save,
  input  logic                       ckpt_restore
);

  localparam int AW = $clog2(AREGS);
  localparam int PW = $clog2(PREGS);
  localparam int FW = $clog2(FLD);
  localparam int CW = $clog2(FLD + 1);
  localparam logic [CW-1:0] C_FLD = CW'(FLD);
  localparam logic [FW-1:0] C_PTR_LAST = FW'(FLD - 1);

  logic [PW-1:0] r_rat [AREGS];
  logic [PW-1:0] r_fl  [FLD];
  logic [FW-1:0] r_rptr;
  logic [FW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          r_out_v;
  logic [PW-1:0] r_out_prd;
  logic [PW-1:0] r_out_old_prd;
  logic          r_out_rdz;
  logic          r_free_err;

  logic          w_restore;
  logic          w_in_rdy;
  logic          w_accept;
  logic          w_pop;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic [PW-1:0] w_head;
  logic [PW-1:0] w_old;
  logic [FW-1:0] w_rptr_nxt;
  logic [FW-1:0] w_wptr_nxt;
  logic [CW-1:0] w_count_nxt;

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef QUPLS4_RENAME_CKPT_EN
  assign w_restore = ckpt_restore;
`else
  logic w_unused_ckpt;
  assign w_restore     = 1'b0;
  assign w_unused_ckpt = ckpt_save ^ ckpt_restore;
`endif

  // A restore flushes the stage, so nothing may be accepted in that cycle.
  assign w_in_rdy   = (!r_out_v || out_rdy) && (in_rdz || (r_count != '0)) && !w_restore;
  assign w_accept   = in_v && w_in_rdy;
  assign w_pop      = w_accept && !in_rdz;
  assign w_full     = (r_count == C_FLD);
  // Physical 0 is hard-wired to architectural 0 and must never re-enter the list.
  assign w_push_req = free_v && (free_preg != '0);
  // A pop in the same cycle makes room even when the list is full.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_head     = r_fl[r_rptr];
  assign w_old      = r_rat[in_rd];

  assign w_rptr_nxt = w_pop  ? ptr_inc(r_rptr) : r_rptr;
  assign w_wptr_nxt = w_push ? ptr_inc(r_wptr) : r_wptr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

`ifdef QUPLS4_RENAME_CKPT_EN
  logic [PW-1:0] r_ckpt_rat [AREGS];
  logic [FW-1:0] r_ckpt_rptr;
  logic [CW-1:0] w_ckpt_diff;
  logic [CW-1:0] w_ckpt_count;

  // Occupancy is the distance from the restored read pointer to the write
  // pointer modulo FLD. Equal pointers are ambiguous: if the list still
  // holds entries, everything between the pointers is free (full list).
  always_comb begin
    w_ckpt_diff = CW'(w_wptr_nxt) - CW'(r_ckpt_rptr);
    if (w_wptr_nxt < r_ckpt_rptr)
      w_ckpt_diff = w_ckpt_diff + C_FLD;
    w_ckpt_count = w_ckpt_diff;
    if ((w_ckpt_diff == '0) && (w_count_nxt != '0))
      w_ckpt_count = C_FLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AREGS; i++)
        r_ckpt_rat[i] <= PW'(i);
      r_ckpt_rptr <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      // Snapshot includes this edge's allocation so a later restore resumes
      // exactly after it.
      for (int i = 0; i < AREGS; i++)
        r_ckpt_rat[i] <= (w_pop && (in_rd == AW'(i))) ? w_head : r_rat[i];
      r_ckpt_rptr <= w_rptr_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AREGS; i++)
        r_rat[i] <= PW'(i);
      for (int k = 0; k < FLD; k++)
        r_fl[k] <= PW'(AREGS + k);
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_count       <= C_FLD;
      r_out_v       <= 1'b0;
      r_out_prd     <= '0;
      r_out_old_prd <= '0;
      r_out_rdz     <= 1'b0;
      r_free_err    <= 1'b0;
    end else begin
      if (w_push)
        r_fl[r_wptr] <= free_preg;
      r_wptr     <= w_wptr_nxt;
      r_free_err <= w_push_req && !w_push;
`ifdef QUPLS4_RENAME_CKPT_EN
      if (ckpt_restore) begin
        r_rat   <= r_ckpt_rat;
        r_rptr  <= r_ckpt_rptr;
        r_count <= w_ckpt_count;
        r_out_v <= 1'b0;
      end else
`endif
      begin
        if (w_pop)
          r_rat[in_rd] <= w_head;
        r_rptr  <= w_rptr_nxt;
        r_count <= w_count_nxt;
        if (w_accept) begin
          r_out_v       <= 1'b1;
          r_out_prd     <= in_rdz ? '0 : w_head;
          r_out_old_prd <= in_rdz ? '0 : w_old;
          r_out_rdz     <= in_rdz;
        end else if (out_rdy) begin
          r_out_v <= 1'b0;
        end
      end
    end
  end

  assign in_rdy      = w_in_rdy;
  assign out_v       = r_out_v;
  assign out_prd     = r_out_prd;
  assign out_old_prd = r_out_old_prd;
  assign out_rdz     = r_out_rdz;
  assign free_err    = r_free_err;
  assign fl_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_qupls4_rename_rd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qupls4_rename_rd
//  Purpose  : Self-checking bench for qupls4_rename_rd. A reference RAT and a
//             free-list queue produce the expected results. These results
//             are pushed into a scoreboard on accept and compared when the
//             stage presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qupls4_rename_rd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_v = 1'b0;
  logic [6:0] in_rd = '0;
  logic       in_rdz = 1'b0;
  logic       in_rdy;
  logic       out_v;
  logic [7:0] out_prd;
  logic [7:0] out_old_prd;
  logic       out_rdz;
  logic       out_rdy = 1'b0;
  logic       free_v = 1'b0;
  logic [7:0] free_preg = '0;
  logic       free_err;
  logic [7:0] fl_count;
  logic       ckpt_save = 1'b0;
  logic       ckpt_restore = 1'b0;

  qupls4_rename_rd dut (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v), .in_rd(in_rd), .in_rdz(in_rdz), .in_rdy(in_rdy),
    .out_v(out_v), .out_prd(out_prd), .out_old_prd(out_old_prd),
    .out_rdz(out_rdz), .out_rdy(out_rdy),
    .free_v(free_v), .free_preg(free_preg), .free_err(free_err),
    .fl_count(fl_count),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prd;
    int old;
    bit rdz;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   rat_m [128];
  int   ck_rat [128];
  int   fl_q [$];
  int   popped_q [$];
  exp_t sb [$];
  bit   exp_outv;
  bit   exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 128; i++) begin
      rat_m[i]  = i;
      ck_rat[i] = i;
    end
    fl_q.delete();
    for (int k = 0; k < 128; k++) fl_q.push_back(128 + k);
    popped_q.delete();
    sb.delete();
    exp_outv = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Reset is asserted at a falling edge. Outputs are checked while reset is
  // held, and reset is released at a later falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    in_v = 1'b0; in_rdz = 1'b0; out_rdy = 1'b0; free_v = 1'b0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0;
    #1;
    model_init();
    chk("rst_out_v", out_v, 0);
    chk("rst_out_prd", out_prd, 0);
    chk("rst_out_old_prd", out_old_prd, 0);
    chk("rst_out_rdz", out_rdz, 0);
    chk("rst_free_err", free_err, 0);
    chk("rst_fl_count", fl_count, 128);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: called and returns at a falling edge.
  task automatic step(input bit v, input int rd, input bit rdz, input bit ordy,
                      input bit fv, input int fp);
    bit   exp_rdy, pop, rst_c;
    exp_t e;
    chk("free_err", free_err, exp_err);
    chk("fl_count", fl_count, fl_q.size());
    chk("out_v", out_v, exp_outv);
    in_v = v; in_rd = rd[6:0]; in_rdz = rdz; out_rdy = ordy;
    free_v = fv; free_preg = fp[7:0];
    rst_c = ckpt_restore;
    #1;
    exp_rdy = (!exp_outv || ordy) && (rdz || fl_q.size() != 0) && !rst_c;
    chk("in_rdy", in_rdy, exp_rdy);
    if (exp_outv) begin
      if (sb.size() == 0) begin
        n_assert++; n_fail++;
        $error("FAIL scoreboard_empty observed=1 expected=0");
      end else begin
        e = sb[0];
        chk("out_prd", out_prd, e.prd);
        chk("out_old_prd", out_old_prd, e.old);
        chk("out_rdz", out_rdz, e.rdz);
        if (ordy) void'(sb.pop_front());
      end
    end
    pop = 1'b0;
    if (v && exp_rdy) begin
      if (rdz) begin
        e.prd = 0; e.old = 0; e.rdz = 1'b1;
      end else begin
        pop = 1'b1;
        e.prd = fl_q.pop_front();
        e.old = rat_m[rd];
        e.rdz = 1'b0;
        rat_m[rd] = e.prd;
        popped_q.push_back(e.prd);
      end
      sb.push_back(e);
    end
    if (fv && fp != 0) begin
      if (fl_q.size() + (pop ? 1 : 0) >= 128 && !pop) exp_err = 1'b1;
      else begin
        exp_err = 1'b0;
        fl_q.push_back(fp);
      end
    end else begin
      exp_err = 1'b0;
    end
    if (rst_c) begin
      fl_q = {popped_q, fl_q};
      rat_m = ck_rat;
      popped_q.delete();
      sb.delete();
      exp_outv = 1'b0;
    end else begin
      if (ckpt_save) begin
        ck_rat = rat_m;
        popped_q.delete();
      end
      if (v && exp_rdy) exp_outv = 1'b1;
      else if (ordy) exp_outv = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    in_v = 1'b0; free_v = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
  endtask

  initial begin
    model_init();
    @(negedge clk);
    do_reset();

    // First allocations: Rd 5 twice, back to back.
    step(1, 5, 0, 1, 0, 0);
    chk("req18_out_v", out_v, 1);
    chk("req18_prd", out_prd, 128);
    chk("req18_old", out_old_prd, 5);
    chk("req18_fl_count", fl_count, 127);
    step(1, 5, 0, 1, 0, 0);
    chk("req19_prd", out_prd, 129);
    chk("req19_old", out_old_prd, 128);

    // Zero destination passes through without allocating.
    step(1, 12, 1, 1, 0, 0);
    chk("rdz_prd", out_prd, 0);
    chk("rdz_flag", out_rdz, 1);
    chk("rdz_fl_count", fl_count, 126);

    // Downstream stall for three cycles, then resume on the same Rd.
    step(1, 9, 0, 1, 0, 0);
    repeat (3) step(1, 9, 0, 0, 0, 0);
    step(1, 9, 0, 1, 0, 0);
    chk("stall_old_prd", out_old_prd, 130);
    step(0, 0, 0, 1, 0, 0);

    // Reset while an output is pending discards it.
    step(1, 5, 0, 0, 0, 0);
    do_reset();
    step(1, 5, 0, 1, 0, 0);
    chk("midrst_prd", out_prd, 128);
    chk("midrst_old", out_old_prd, 5);
    do_reset();

    // Drain the free list completely.
    for (int i = 0; i < 128; i++) step(1, (i * 37) % 128, 0, 1, 0, 0);
    chk("empty_fl_count", fl_count, 0);
    in_v = 1'b1; in_rd = 7'd3; in_rdz = 1'b0; out_rdy = 1'b1;
    #1 chk("empty_rdy_alloc", in_rdy, 0);
    in_rdz = 1'b1;
    #1 chk("empty_rdy_rdz", in_rdy, 1);
    in_v = 1'b0;
    step(0, 0, 0, 1, 1, 0);      // register 0 is never freed
    step(1, 3, 0, 1, 1, 7);      // free into empty list: no bypass
    step(1, 3, 0, 1, 0, 0);
    chk("refill_prd", out_prd, 7);
    step(0, 0, 0, 1, 0, 0);

    // Overflowing free into a full list.
    do_reset();
    step(0, 0, 0, 1, 1, 200);
    chk("ovf_free_err", free_err, 1);
    chk("ovf_fl_count", fl_count, 128);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf_err_pulse", free_err, 0);
    step(1, 1, 0, 1, 1, 201);    // pop and push together at full
    chk("pushpop_fl_count", fl_count, 128);
    chk("pushpop_err", free_err, 0);
    step(0, 0, 0, 1, 0, 0);

`ifdef QUPLS4_RENAME_CKPT_EN
    do_reset();
    ckpt_save = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    repeat (3) step(1, 5, 0, 1, 0, 0);
    ckpt_restore = 1'b1;
    step(1, 5, 0, 1, 0, 0);
    chk("ckpt_fl_count", fl_count, 128);
    chk("ckpt_out_v", out_v, 0);
    step(1, 5, 0, 1, 0, 0);
    chk("ckpt_prd", out_prd, 128);
    chk("ckpt_old", out_old_prd, 5);
    step(0, 0, 0, 1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
